// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state, default width and bit-index type for serial_subtractor
package serial_sub_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  typedef logic [5:0] bit_idx_t;
endpackage

// File: rtl/half_subtractor.sv
// half_subtractor: one-bit difference and borrow of i_bit1 - i_bit2
module half_subtractor (
  input  logic i_bit1,
  input  logic i_bit2,
  output logic o_diff,
  output logic o_borrow
);
  assign o_diff   = i_bit1 ^ i_bit2;
  assign o_borrow = ~i_bit1 & i_bit2;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A-B, LSB first, one bit per cycle, valid/ready handshakes.
// Define SERIAL_SUB_SAT_EN to clamp the difference to zero on a final borrow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);
  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;
  logic             borrow;
  bit_idx_t         idx;
  logic             d1;
  logic             b1;
  logic             d;
  logic             b2;
  // two half subtractors chained through the running borrow form the full-subtractor cell
  half_subtractor u_hs_ab (.i_bit1(a[0]), .i_bit2(b[0]), .o_diff(d1), .o_borrow(b1));
  half_subtractor u_hs_br (.i_bit1(d1), .i_bit2(borrow), .o_diff(d), .o_borrow(b2));
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      res    <= '0;
      borrow <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          a      <= i_minuend;
          b      <= i_subtrahend;
          borrow <= 1'b0;
          idx    <= '0;
          state  <= RUN;
        end
        RUN: begin
          a      <= a >> 1;
          b      <= b >> 1;
          res    <= {d, res[WIDTH-1:1]};
          borrow <= b1 | b2;
          idx    <= idx + bit_idx_t'(1);
          if (idx == bit_idx_t'(WIDTH - 1)) state <= DONE;
        end
        DONE: if (i_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign o_ready  = state == IDLE;
  assign o_valid  = state == DONE;
  assign o_borrow = borrow;
`ifdef SERIAL_SUB_SAT_EN
  assign o_diff = borrow ? '0 : res;
`else
  assign o_diff = res;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor at WIDTH=8
module tb_serial_subtractor;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_minuend = '0;
  logic [7:0] i_subtrahend = '0;
  logic       o_valid;
  logic       i_ready = 1'b1;
  logic [7:0] o_diff;
  logic       o_borrow;
  typedef struct {
    logic [7:0] d;
    logic       b;
    int         acc;
  } exp_t;
  exp_t sb[$];
  int   acc_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  serial_subtractor #(.WIDTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_minuend(i_minuend), .i_subtrahend(i_subtrahend), .o_valid(o_valid),
    .i_ready(i_ready), .o_diff(o_diff), .o_borrow(o_borrow)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int acc);
    logic [8:0] t;
    exp_t e;
    t = {1'b0, a} - {1'b0, b};
    e.b = t[8];
`ifdef SERIAL_SUB_SAT_EN
    e.d = t[8] ? 8'd0 : t[7:0];
`else
    e.d = t[7:0];
`endif
    e.acc = acc;
    return e;
  endfunction
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst) begin
      if (i_valid && o_ready) begin
        sb.push_back(model(i_minuend, i_subtrahend, cyc + 1));
        acc_log.push_back(cyc + 1);
      end
      if (o_valid && !prev_valid) begin
        if (sb.size() == 0) check("spurious_valid", 32'(o_valid), 0);
        else check("latency", 32'(cyc - sb[0].acc), 8);
      end
      if (o_valid && i_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check("diff", 32'(o_diff), 32'(e.d));
        check("borrow", 32'(o_borrow), 32'(e.b));
      end
    end
    prev_valid = o_valid;
  end
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(posedge i_clk);
    #1 i_minuend = a;
    i_subtrahend = b;
    i_valid = 1'b1;
    @(negedge i_clk);
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 0, 1);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(negedge i_clk);
      n++;
    end
    check("drain", 32'(sb.size()), 0);
  endtask
  initial begin
    int n;
    #2;
    check("rst_ready", 32'(o_ready), 1);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_diff", 32'(o_diff), 0);
    check("rst_borrow", 32'(o_borrow), 0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    i_minuend = 8'd200;
    i_subtrahend = 8'd55;
    i_valid = 1'b1;
    @(negedge i_clk);
    check("ready_after_rst", 32'(o_ready), 1);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    drain();
    send(8'd5, 8'd10);
    drain();
    send(8'd255, 8'd255);
    drain();
    send(8'd0, 8'd255);
    drain();
    send(8'd128, 8'd127);
    drain();
    for (int k = 0; k < 4; k++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      drain();
    end
    i_ready = 1'b0;
    send(8'd100, 8'd30);
    repeat (3) begin
      @(posedge i_clk);
      #1 i_valid = 1'b1;
      i_minuend = 8'd1;
      i_subtrahend = 8'd2;
      @(posedge i_clk);
      #1 i_valid = 1'b0;
    end
    n = 0;
    while (!o_valid && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check("bp_valid_rise", 32'(o_valid), 1);
    repeat (5) begin
      @(posedge i_clk);
      #1 i_valid = ~i_valid;
      @(negedge i_clk);
      check("bp_valid_hold", 32'(o_valid), 1);
      check("bp_diff_hold", 32'(o_diff), 32'(8'd70));
      check("bp_borrow_hold", 32'(o_borrow), 0);
    end
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    i_ready = 1'b1;
    drain();
    send(8'd77, 8'd11);
    repeat (2) @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("abort_ready", 32'(o_ready), 1);
    check("abort_valid", 32'(o_valid), 0);
    check("abort_diff", 32'(o_diff), 0);
    check("abort_borrow", 32'(o_borrow), 0);
    sb.delete();
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    n = 0;
    repeat (12) begin
      @(negedge i_clk);
      if (o_valid) n++;
    end
    check("abort_no_valid", 32'(n), 0);
    send(8'd9, 8'd4);
    drain();
    acc_log.delete();
    @(posedge i_clk);
    #1 i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_minuend = 8'(50 + 40 * k);
      i_subtrahend = 8'(7 * k + 3);
      n = 0;
      @(negedge i_clk);
      while (!o_ready && n < 30) begin
        @(negedge i_clk);
        n++;
      end
      if (n >= 30) check("b2b_timeout", 0, 1);
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    drain();
    check("b2b_count", 32'(acc_log.size()), 3);
    if (acc_log.size() == 3) begin
      check("b2b_gap0", 32'(acc_log[1] - acc_log[0]), 10);
      check("b2b_gap1", 32'(acc_log[2] - acc_log[1]), 10);
    end
    repeat (3) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, legal range 2..32.
REQ-002 SHALL have port i_clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1: reset; asynchronous, active-high.
REQ-004 SHALL have port i_valid, input, 1: operand pair offered.
REQ-005 SHALL have port o_ready, output, 1: block can accept operands.
REQ-006 SHALL have port i_minuend, input, WIDTH: operand A.
REQ-007 SHALL have port i_subtrahend, input, WIDTH: operand B.
REQ-008 SHALL have port o_valid, output, 1: result available.
REQ-009 SHALL have port i_ready, input, 1: consumer takes the result.
REQ-010 SHALL have port o_diff, output, WIDTH: A minus B.
REQ-011 SHALL have port o_borrow, output, 1: final borrow out, set when A < B unsigned.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE SHALL drive o_ready=1 and o_valid=0.
REQ-014 In IDLE, i_valid&&o_ready at an edge SHALL latch both operands, clear borrow and bit index to 0, and enter RUN.
REQ-015 RUN SHALL process one bit per cycle, LSB first, for exactly WIDTH cycles.
REQ-016 Each RUN bit SHALL compute diff = A[i]^B[i]^borrow and borrow_next = (~A[i]&B[i]) | (~(A[i]^B[i])&borrow).
REQ-017 Each RUN cycle SHALL shift the diff bit into the result register.
REQ-018 After the edge that processes bit WIDTH-1, the FSM SHALL enter DONE; o_valid rises exactly WIDTH cycles after the accepting edge.
REQ-019 DONE SHALL hold o_valid=1 and keep o_diff and o_borrow stable until o_valid&&i_ready.
REQ-020 On o_valid&&i_ready the FSM SHALL return to IDLE.
REQ-021 o_ready SHALL be 0 in RUN and DONE; i_valid and operand changes there SHALL be ignored.
REQ-022 A new operand pair SHALL NOT be accepted in the cycle the result is taken; minimum spacing between accepts is WIDTH+2 cycles.
REQ-023 Without saturation, o_diff SHALL equal (A-B) mod 2^WIDTH.
REQ-024 Operand sets A=B SHALL yield o_diff=0 and o_borrow=0.
REQ-025 o_diff and o_borrow are don't-care while o_valid=0; benches SHALL NOT check them then.

Reset
REQ-026 Asserting i_rst SHALL immediately force IDLE, o_valid=0, o_ready=1, o_diff=0, o_borrow=0, and clear the borrow and bit index.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation; no result is ever presented for it.
REQ-028 The first accept SHALL be possible at the first rising edge after i_rst deasserts.

Configuration
REQ-029 Macro SERIAL_SUB_SAT_EN SHALL select saturation.
REQ-030 With SERIAL_SUB_SAT_EN defined, a final borrow of 1 SHALL force o_diff=0 while o_borrow stays 1.
REQ-031 Without SERIAL_SUB_SAT_EN, o_diff SHALL be the wrapped difference and no saturation logic SHALL exist.

Structure
REQ-032 A shared package serial_sub_pkg SHALL hold the FSM state enum, the default WIDTH constant, and a width-safe bit-index type.
REQ-033 Per-bit logic SHALL be a sub-module half_subtractor, instantiated twice to form the full-subtractor bit cell.
REQ-034 half_subtractor SHALL have inputs i_bit1 and i_bit2 and outputs o_diff = i_bit1^i_bit2 and o_borrow = ~i_bit1&i_bit2.

Verification (WIDTH=8)
REQ-035 Basic subtract: A=200, B=55, i_ready=1 -> o_valid 8 cycles after the accept with o_diff=145, o_borrow=0.
REQ-036 Underflow: A=5, B=10 -> o_borrow=1; o_diff=251 without the macro, 0 with SERIAL_SUB_SAT_EN.
REQ-037 Boundary operands: A=B=255 -> o_diff=0, o_borrow=0; A=0, B=255 -> o_diff=1, o_borrow=1 (0 when saturating).
REQ-038 Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid, o_diff and o_borrow stable; i_valid pulses in RUN and DONE are ignored.
REQ-039 Reset mid-operation: assert i_rst in RUN cycle 3 -> outputs return to reset values at once and no o_valid appears; then A=9, B=4 -> o_diff=5.
REQ-040 Back-to-back: i_valid held high with 3 operand pairs -> accepts spaced exactly 10 cycles apart, results in order.
